// File: rtl/flash_bus_phy_if.sv
// Request/response and flash pin bundle for flash_bus_phy; master = sequencer/board side, slave = phy.
// flash_ry_by_n exists only when FLASH_RDY_EN is defined.
interface flash_bus_phy_if;
    logic        wr_en;
    logic [24:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_done;
    logic        rd_en;
    logic [24:0] rd_addr;
    logic [16:0] rd_length;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_done;
    logic        flash_ce_n;
    logic        flash_oe_n;
    logic        flash_we_n;
    logic [24:0] flash_addr;
    logic [15:0] flash_dq_o;
    logic        flash_dq_oe;
    logic [15:0] flash_dq_i;
`ifdef FLASH_RDY_EN
    logic        flash_ry_by_n;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, rd_length, flash_dq_i, flash_ry_by_n,
        input  wr_done, rd_data, rd_valid, rd_done,
        input  flash_ce_n, flash_oe_n, flash_we_n, flash_addr, flash_dq_o, flash_dq_oe
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, rd_length, flash_dq_i, flash_ry_by_n,
        output wr_done, rd_data, rd_valid, rd_done,
        output flash_ce_n, flash_oe_n, flash_we_n, flash_addr, flash_dq_o, flash_dq_oe
    );
`else
    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, rd_length, flash_dq_i,
        input  wr_done, rd_data, rd_valid, rd_done,
        input  flash_ce_n, flash_oe_n, flash_we_n, flash_addr, flash_dq_o, flash_dq_oe
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, rd_length, flash_dq_i,
        output wr_done, rd_data, rd_valid, rd_done,
        output flash_ce_n, flash_oe_n, flash_we_n, flash_addr, flash_dq_o, flash_dq_oe
    );
`endif
endinterface

// File: rtl/flash_bus_phy.sv
// Pin-level CE#/OE#/WE# sequencer for a 16-bit async NOR flash; optional FLASH_RDY_EN adds RY/BY# wait.
// Latency: write done 8 cycles after capture (defaults); read word k at T_RD + k*(T_RD+T_GAP).
// No backpressure: requests are accepted only in IDLE, anything arriving while busy is dropped.
module flash_bus_phy #(
    parameter int T_ADDR_SETUP = 2,
    parameter int T_WE         = 4,
    parameter int T_HOLD       = 2,
    parameter int T_RD         = 8,
    parameter int T_GAP        = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    flash_bus_phy_if.slave bus
);
    localparam int M1    = (T_ADDR_SETUP > T_WE) ? T_ADDR_SETUP : T_WE;
    localparam int M2    = (M1 > T_HOLD) ? M1 : T_HOLD;
    localparam int M3    = (M2 > T_RD) ? M2 : T_RD;
    localparam int MAX_T = (M3 > T_GAP) ? M3 : T_GAP;
    localparam int CW    = $clog2(MAX_T + 1);

`ifdef FLASH_RDY_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0, WR_SETUP = 3'd1, WR_PULSE = 3'd2, WR_HOLD = 3'd3,
        RD_ACCESS = 3'd4, RD_GAP = 3'd5, DONE = 3'd6, WR_BUSY = 3'd7
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0, WR_SETUP = 3'd1, WR_PULSE = 3'd2, WR_HOLD = 3'd3,
        RD_ACCESS = 3'd4, RD_GAP = 3'd5, DONE = 3'd6
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [16:0]   rem_q, rem_d;
    logic          op_rd_q, op_rd_d;
    logic          ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic [24:0]   addr_q, addr_d;
    logic [15:0]   dq_o_q, dq_o_d;
    logic          dq_oe_q, dq_oe_d;
    logic [15:0]   rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d, rd_done_q, rd_done_d, wr_done_q, wr_done_d;

    logic          rd_go;
    logic [24:0]   rd_src_addr;
    logic [16:0]   rd_src_len;

`ifdef FLASH_RDY_EN
    logic [1:0] ry_sync_q;
    logic       ry_sync;
    logic       rd_pend_q, rd_pend_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ry_sync_q <= 2'b00;
        else        ry_sync_q <= {ry_sync_q[0], bus.flash_ry_by_n};
    end
    assign ry_sync = ry_sync_q[1];

    // A read held off by a busy flash is parked in addr_q/rem_q until ready returns.
    assign rd_go       = (rd_pend_q | bus.rd_en) & ry_sync;
    assign rd_src_addr = rd_pend_q ? addr_q : bus.rd_addr;
    assign rd_src_len  = rd_pend_q ? rem_q  : bus.rd_length;
`else
    assign rd_go       = bus.rd_en;
    assign rd_src_addr = bus.rd_addr;
    assign rd_src_len  = bus.rd_length;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        op_rd_d    = op_rd_q;
        ce_n_d     = ce_n_q;
        oe_n_d     = oe_n_q;
        we_n_d     = we_n_q;
        addr_d     = addr_q;
        dq_o_d     = dq_o_q;
        dq_oe_d    = dq_oe_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rd_done_d  = 1'b0;
        wr_done_d  = 1'b0;
`ifdef FLASH_RDY_EN
        rd_pend_d  = rd_pend_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.wr_en) begin
                    state_d = WR_SETUP;
                    cnt_d   = CW'(T_ADDR_SETUP - 1);
                    op_rd_d = 1'b0;
                    ce_n_d  = 1'b0;
                    addr_d  = bus.wr_addr;
                    dq_o_d  = bus.wr_data;
                    dq_oe_d = 1'b1;
`ifdef FLASH_RDY_EN
                    rd_pend_d = 1'b0;
`endif
                end else if (rd_go) begin
                    op_rd_d = 1'b1;
                    addr_d  = rd_src_addr;
                    rem_d   = rd_src_len;
`ifdef FLASH_RDY_EN
                    rd_pend_d = 1'b0;
`endif
                    if (rd_src_len == 17'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RD_ACCESS;
                        cnt_d   = CW'(T_RD - 1);
                        ce_n_d  = 1'b0;
                        oe_n_d  = 1'b0;
                    end
                end
`ifdef FLASH_RDY_EN
                else if (bus.rd_en && !rd_pend_q) begin
                    rd_pend_d = 1'b1;
                    addr_d    = bus.rd_addr;
                    rem_d     = bus.rd_length;
                end
`endif
            end
            WR_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = WR_PULSE;
                    cnt_d   = CW'(T_WE - 1);
                    we_n_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = WR_HOLD;
                    cnt_d   = CW'(T_HOLD - 1);
                    we_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR_HOLD: begin
                if (cnt_q == '0) begin
                    ce_n_d  = 1'b1;
                    dq_oe_d = 1'b0;
`ifdef FLASH_RDY_EN
                    state_d = WR_BUSY;
`else
                    state_d   = DONE;
                    wr_done_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef FLASH_RDY_EN
            WR_BUSY: begin
                if (ry_sync) begin
                    state_d   = DONE;
                    wr_done_d = 1'b1;
                end
            end
`endif
            RD_ACCESS: begin
                if (cnt_q == '0) begin
                    rd_data_d  = bus.flash_dq_i;
                    rd_valid_d = 1'b1;
                    ce_n_d     = 1'b1;
                    oe_n_d     = 1'b1;
                    if (rem_q == 17'd1) begin
                        state_d = DONE;
                    end else begin
                        state_d = RD_GAP;
                        cnt_d   = CW'(T_GAP - 1);
                        rem_d   = rem_q - 17'd1;
                        addr_d  = addr_q + 25'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RD_GAP: begin
                if (cnt_q == '0) begin
                    state_d = RD_ACCESS;
                    cnt_d   = CW'(T_RD - 1);
                    ce_n_d  = 1'b0;
                    oe_n_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                // Write completion is flagged on entry; read completion lands one cycle after the last word.
                state_d   = IDLE;
                rd_done_d = op_rd_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            op_rd_q    <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            addr_q     <= '0;
            dq_o_q     <= '0;
            dq_oe_q    <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_done_q  <= 1'b0;
            wr_done_q  <= 1'b0;
`ifdef FLASH_RDY_EN
            rd_pend_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            op_rd_q    <= op_rd_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            addr_q     <= addr_d;
            dq_o_q     <= dq_o_d;
            dq_oe_q    <= dq_oe_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_done_q  <= rd_done_d;
            wr_done_q  <= wr_done_d;
`ifdef FLASH_RDY_EN
            rd_pend_q  <= rd_pend_d;
`endif
        end
    end

    assign bus.flash_ce_n  = ce_n_q;
    assign bus.flash_oe_n  = oe_n_q;
    assign bus.flash_we_n  = we_n_q;
    assign bus.flash_addr  = addr_q;
    assign bus.flash_dq_o  = dq_o_q;
    assign bus.flash_dq_oe = dq_oe_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_done     = rd_done_q;
    assign bus.wr_done     = wr_done_q;
endmodule

// File: tb/tb_flash_bus_phy.sv
// Directed bench for flash_bus_phy; flash model returns flash_addr ^ 0xA5A5 on DQ.
module tb_flash_bus_phy;
    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

`ifdef FLASH_RDY_EN
    localparam int WR_LAT = 9;
`else
    localparam int WR_LAT = 8;
`endif

    flash_bus_phy_if bus_if ();

    flash_bus_phy dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    assign bus_if.flash_dq_i = bus_if.flash_addr[15:0] ^ 16'hA5A5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n_wd, n_rv, n_rd;
        logic [24:0] exp_addr;

        rst_n            = 1'b0;
        bus_if.wr_en     = 1'b0;
        bus_if.wr_addr   = '0;
        bus_if.wr_data   = '0;
        bus_if.rd_en     = 1'b0;
        bus_if.rd_addr   = '0;
        bus_if.rd_length = '0;
`ifdef FLASH_RDY_EN
        bus_if.flash_ry_by_n = 1'b1;
`endif
        repeat (3) tick();
        chk("rst_ce_n",  bus_if.flash_ce_n,  1);
        chk("rst_oe_n",  bus_if.flash_oe_n,  1);
        chk("rst_we_n",  bus_if.flash_we_n,  1);
        chk("rst_dq_oe", bus_if.flash_dq_oe, 0);
        chk("rst_addr",  bus_if.flash_addr,  0);
        chk("rst_dq_o",  bus_if.flash_dq_o,  0);
        chk("rst_rdata", bus_if.rd_data,     0);
        chk("rst_pulses", {bus_if.rd_valid, bus_if.rd_done, bus_if.wr_done}, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Single write
        bus_if.wr_addr = 25'h6407;
        bus_if.wr_data = 16'h0060;
        bus_if.wr_en   = 1'b1;
        tick();
        bus_if.wr_en = 1'b0;
        for (int k = 0; k <= WR_LAT + 1; k++) begin
            chk("wr_ce_n",  bus_if.flash_ce_n,  (k < 8) ? 1'b0 : 1'b1);
            chk("wr_we_n",  bus_if.flash_we_n,  (k >= 2 && k < 6) ? 1'b0 : 1'b1);
            chk("wr_oe_n",  bus_if.flash_oe_n,  1);
            chk("wr_dq_oe", bus_if.flash_dq_oe, (k < 8) ? 1'b1 : 1'b0);
            chk("wr_done",  bus_if.wr_done,     (k == WR_LAT) ? 1'b1 : 1'b0);
            if (k < 8) begin
                chk("wr_addr", bus_if.flash_addr, 25'h6407);
                chk("wr_dq_o", bus_if.flash_dq_o, 16'h0060);
            end
            tick();
        end

        // Three-word read from 0x10
        bus_if.rd_addr   = 25'h10;
        bus_if.rd_length = 17'd3;
        bus_if.rd_en     = 1'b1;
        tick();
        bus_if.rd_en = 1'b0;
        for (int k = 0; k <= 31; k++) begin
            chk("rd3_valid", bus_if.rd_valid, (k == 8 || k == 18 || k == 28) ? 1'b1 : 1'b0);
            chk("rd3_done",  bus_if.rd_done,  (k == 29) ? 1'b1 : 1'b0);
            chk("rd3_ce_n",  bus_if.flash_ce_n, ((k % 10) < 8 && k < 28) ? 1'b0 : 1'b1);
            chk("rd3_oe_n",  bus_if.flash_oe_n, ((k % 10) < 8 && k < 28) ? 1'b0 : 1'b1);
            chk("rd3_we_n",  bus_if.flash_we_n, 1);
            chk("rd3_dq_oe", bus_if.flash_dq_oe, 0);
            if (k == 0)  chk("rd3_addr0", bus_if.flash_addr, 25'h10);
            if (k == 10) chk("rd3_addr1", bus_if.flash_addr, 25'h11);
            if (k == 20) chk("rd3_addr2", bus_if.flash_addr, 25'h12);
            if (k == 8)  chk("rd3_data0", bus_if.rd_data, 16'hA5B5);
            if (k == 18) chk("rd3_data1", bus_if.rd_data, 16'hA5B4);
            if (k == 28) chk("rd3_data2", bus_if.rd_data, 16'hA5B7);
            tick();
        end

        // Zero-length read
        bus_if.rd_addr   = 25'h55;
        bus_if.rd_length = 17'd0;
        bus_if.rd_en     = 1'b1;
        tick();
        bus_if.rd_en = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            chk("rd0_done",  bus_if.rd_done,    (k == 1) ? 1'b1 : 1'b0);
            chk("rd0_valid", bus_if.rd_valid,   0);
            chk("rd0_ce_n",  bus_if.flash_ce_n, 1);
            tick();
        end

        // Address wrap at the top of the 25-bit space
        bus_if.rd_addr   = 25'h1FFFFFF;
        bus_if.rd_length = 17'd2;
        bus_if.rd_en     = 1'b1;
        tick();
        bus_if.rd_en = 1'b0;
        for (int k = 0; k <= 21; k++) begin
            if (k == 0)  chk("wrap_addr0", bus_if.flash_addr, 25'h1FFFFFF);
            if (k == 10) chk("wrap_addr1", bus_if.flash_addr, 25'h0);
            if (k == 8)  chk("wrap_data0", bus_if.rd_data, 16'h5A5A);
            if (k == 18) chk("wrap_data1", bus_if.rd_data, 16'hA5A5);
            chk("wrap_valid", bus_if.rd_valid, (k == 8 || k == 18) ? 1'b1 : 1'b0);
            chk("wrap_done",  bus_if.rd_done,  (k == 19) ? 1'b1 : 1'b0);
            tick();
        end

        // Simultaneous write+read, then a read while the write is busy
        bus_if.wr_addr   = 25'h123;
        bus_if.wr_data   = 16'hBEEF;
        bus_if.rd_addr   = 25'h200;
        bus_if.rd_length = 17'd1;
        bus_if.wr_en     = 1'b1;
        bus_if.rd_en     = 1'b1;
        tick();
        bus_if.wr_en = 1'b0;
        bus_if.rd_en = 1'b0;
        n_wd = 0; n_rv = 0; n_rd = 0;
        for (int k = 0; k <= 40; k++) begin
            if (bus_if.wr_done)  n_wd++;
            if (bus_if.rd_valid) n_rv++;
            if (bus_if.rd_done)  n_rd++;
            if (k == 0) chk("both_dq_o", bus_if.flash_dq_o, 16'hBEEF);
            bus_if.rd_en = (k == 3) ? 1'b1 : 1'b0;
            tick();
        end
        chk("both_wr_done_cnt",  n_wd, 1);
        chk("both_rd_valid_cnt", n_rv, 0);
        chk("both_rd_done_cnt",  n_rd, 0);

        // Asynchronous reset in the middle of a read access
        bus_if.rd_addr   = 25'h40;
        bus_if.rd_length = 17'd3;
        bus_if.rd_en     = 1'b1;
        tick();
        bus_if.rd_en = 1'b0;
        repeat (4) tick();
        chk("arst_pre_ce_n", bus_if.flash_ce_n, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ce_n",  bus_if.flash_ce_n,  1);
        chk("arst_oe_n",  bus_if.flash_oe_n,  1);
        chk("arst_we_n",  bus_if.flash_we_n,  1);
        chk("arst_dq_oe", bus_if.flash_dq_oe, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        n_rv = 0; n_rd = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus_if.rd_valid) n_rv++;
            if (bus_if.rd_done)  n_rd++;
            tick();
        end
        chk("arst_rd_valid_cnt", n_rv, 0);
        chk("arst_rd_done_cnt",  n_rd, 0);

`ifdef FLASH_RDY_EN
        // Flash busy for 20 cycles after WE# rises
        bus_if.flash_ry_by_n = 1'b0;
        bus_if.wr_addr = 25'h77;
        bus_if.wr_data = 16'h1234;
        bus_if.wr_en   = 1'b1;
        tick();
        bus_if.wr_en = 1'b0;
        for (int k = 0; k <= 32; k++) begin
            chk("ry_wr_done", bus_if.wr_done, (k == 29) ? 1'b1 : 1'b0);
            if (k == 26) bus_if.flash_ry_by_n = 1'b1;
            tick();
        end
`endif
        exp_addr = 25'h0;
        chk("final_idle_ce_n", bus_if.flash_ce_n, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
